// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer.
// The GAP state is always part of the enum; it is only reachable when
// PULSE_SEQUENCER_BURST_EN is defined.
package pulse_seq_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 32;
  localparam int unsigned BURST_W_DEFAULT = 16;
  localparam int unsigned ZeroCnt         = 0;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StPulse,
    StGap
  } seq_state_e;

endpackage

// File: rtl/pulse_seq_counter.sv
// Loadable down-counter with zero flag. Load has priority over decrement,
// and decrement saturates at zero.
module pulse_seq_counter
  import pulse_seq_pkg::*;
#(
  parameter int unsigned Width = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count;

  // Count register: synchronous active-low reset, load wins over decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= Width'(ZeroCnt);
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != Width'(ZeroCnt))) begin
      count <= count - Width'(1);
    end
  end

  assign zero = (count == Width'(ZeroCnt));

endmodule

// File: rtl/pulse_sequencer.sv
// Single timed pulse generator driven by the HPS pulse-control PIOs.
// A rising edge on start_i latches delay/width and produces one pulse of
// width cycles, delay+1 cycles after the trigger edge.
// Optional: PULSE_SEQUENCER_BURST_EN adds burst_i/period_i for pulse trains.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
`ifdef PULSE_SEQUENCER_BURST_EN
  , parameter int unsigned BURST_W = BURST_W_DEFAULT
`endif
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [CNT_W-1:0]   delay_i,
  input  logic [CNT_W-1:0]   width_i,
`ifdef PULSE_SEQUENCER_BURST_EN
  input  logic [BURST_W-1:0] burst_i,
  input  logic [CNT_W-1:0]   period_i,
`endif
  output logic               pulse_o,
  output logic               busy_o,
  output logic               done_o
);

  seq_state_e       state_q;
  logic             start_q;
  logic [CNT_W-1:0] width_q;
  logic             trigger;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

`ifdef PULSE_SEQUENCER_BURST_EN
  logic [CNT_W-1:0]   period_q;
  logic               burst_load;
  logic [BURST_W-1:0] burst_load_val;
  logic               burst_dec;
  logic               burst_zero;

  // Counts pulses still to come after the current one; burst_i=0 acts as 1.
  assign burst_load_val = (burst_i == '0) ? '0 : burst_i - BURST_W'(1);
`endif

  // Abort in idle also blocks the trigger, so the start edge is consumed.
  assign trigger = start_i && !start_q && (state_q == StIdle) && !abort_i;

  // Counter control derived from the current state and the zero flag.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = delay_i;
    cnt_dec      = 1'b0;
`ifdef PULSE_SEQUENCER_BURST_EN
    burst_load   = 1'b0;
    burst_dec    = 1'b0;
`endif
    if (!abort_i) begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            cnt_load = 1'b1;
`ifdef PULSE_SEQUENCER_BURST_EN
            burst_load = 1'b1;
`endif
          end
        end
        StDelay, StGap: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (width_q != '0) begin
            cnt_load     = 1'b1;
            cnt_load_val = width_q - CNT_W'(1);
          end
        end
        StPulse: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end
`ifdef PULSE_SEQUENCER_BURST_EN
          else if (!burst_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = period_q;
            burst_dec    = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      width_q <= '0;
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef PULSE_SEQUENCER_BURST_EN
      period_q <= '0;
`endif
    end else begin
      start_q <= start_i;
      done_o  <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q <= StIdle;
        pulse_o <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (trigger) begin
              width_q <= width_i;
`ifdef PULSE_SEQUENCER_BURST_EN
              period_q <= period_i;
`endif
              state_q <= StDelay;
              busy_o  <= 1'b1;
            end
          end
          StDelay: begin
            if (cnt_zero) begin
              if (width_q != '0) begin
                state_q <= StPulse;
                pulse_o <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
            end
          end
          StPulse: begin
            if (cnt_zero) begin
              pulse_o <= 1'b0;
`ifdef PULSE_SEQUENCER_BURST_EN
              if (!burst_zero) begin
                state_q <= StGap;
              end else begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
`else
              state_q <= StIdle;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
`endif
            end
          end
          StGap: begin
            if (cnt_zero) begin
              state_q <= StPulse;
              pulse_o <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Shared delay / width / period counter.
  pulse_seq_counter #(
    .Width (CNT_W)
  ) u_cnt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef PULSE_SEQUENCER_BURST_EN
  // Remaining-pulse counter for bursts.
  pulse_seq_counter #(
    .Width (BURST_W)
  ) u_burst_cnt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (burst_load),
    .load_val (burst_load_val),
    .dec      (burst_dec),
    .zero     (burst_zero)
  );
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer. A timeline model predicts the
// outputs from the trigger edge and the latched delay/width (and burst/period
// when PULSE_SEQUENCER_BURST_EN is defined); directed cases pin it with literals.
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] delay = '0;
  logic [31:0] width = '0;
`ifdef PULSE_SEQUENCER_BURST_EN
  logic [15:0] burst = 16'd1;
  logic [31:0] period = '0;
`endif
  logic        pulse;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pulse_sequencer dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .delay_i       (delay),
    .width_i       (width),
`ifdef PULSE_SEQUENCER_BURST_EN
    .burst_i       (burst),
    .period_i      (period),
`endif
    .pulse_o       (pulse),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic check(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Timeline model: a sequence triggered at edge t0 is a set of windows in k = edge - t0.
  longint n = 0, t0 = 0, md = 0, mw = 0, mb = 1, mp = 0, mend = 0, k = 0;
  bit     act = 0, sprev = 0;
  logic   ep = 0, eb = 0, ed = 0;

  function automatic logic in_pulse(input longint kk);
    longint base;
    if (mw == 0) return 1'b0;
    for (longint j = 0; j < mb; j++) begin
      base = md + 1 + j * (mw + mp + 1);
      if (kk >= base && kk < base + mw) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      ep = 1'b0; eb = 1'b0; ed = 1'b0;
      if (!rst_n) begin
        act = 0;
        sprev = 0;
      end else begin
        if (act) begin
          k = n - t0;
          if (abort) begin
            act = 0;
          end else begin
            ep = in_pulse(k);
            eb = (k < mend);
            ed = (k == mend);
            if (k == mend) act = 0;
          end
        end else if (start && !sprev && !abort) begin
          t0 = n;
          md = longint'(delay);
          mw = longint'(width);
          mb = 1;
          mp = 0;
`ifdef PULSE_SEQUENCER_BURST_EN
          mb = (burst == 0) ? 1 : longint'(burst);
          mp = longint'(period);
`endif
          mend = (mw == 0) ? md + 1 : md + 1 + mb * mw + (mb - 1) * (mp + 1);
          act = 1;
          eb = 1'b1;
        end
        sprev = start;
      end
      n++;
      @(negedge clk);
      check("model/pulse", pulse, ep);
      check("model/busy", busy, eb);
      check("model/done", done, ed);
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Trigger with (d, w) and compare k = 0..ncyc-1 against literal bit patterns.
  task automatic lit(input string nm, input int d, input int w, input int ncyc,
                     input logic [15:0] lp, input logic [15:0] lb, input logic [15:0] ld);
    next_edge();
    delay = d;
    width = w;
    start = 1'b1;
    next_edge();
    start = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check({nm, "/pulse"}, pulse, lp[i]);
      check({nm, "/busy"}, busy, lb[i]);
      check({nm, "/done"}, done, ld[i]);
    end
    repeat (2) next_edge();
  endtask

  initial begin
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset/pulse", pulse, 1'b0);
      check("reset/busy", busy, 1'b0);
      check("reset/done", done, 1'b0);
    end
    next_edge();
    rst_n = 1'b1;
    repeat (5) next_edge();
    check("idle/busy", busy, 1'b0);

    lit("d0w1", 0, 1, 4, 16'h0002, 16'h0003, 16'h0004);
    lit("d5w3", 5, 3, 11, 16'h01C0, 16'h01FF, 16'h0200);
    lit("d4w0", 4, 0, 7, 16'h0000, 16'h001F, 16'h0020);
`ifdef PULSE_SEQUENCER_BURST_EN
    burst = 16'd3;
    period = 32'd1;
    lit("burst", 2, 2, 15, 16'h1998, 16'h1FFF, 16'h2000);
    burst = 16'd1;
    period = 32'd0;
`endif

    // D=10, W=10: restart edge while busy is ignored, abort during the pulse.
    next_edge();
    delay = 10;
    width = 10;
    start = 1'b1;
    next_edge();
    start = 1'b0;
    next_edge();
    next_edge();
    start = 1'b1;
    repeat (9) next_edge();
    abort = 1'b1;
    @(negedge clk);
    check("abort/pulse_before", pulse, 1'b1);
    @(negedge clk);
    check("abort/pulse_after", pulse, 1'b0);
    check("abort/busy_after", busy, 1'b0);
    next_edge();
    abort = 1'b0;
    start = 1'b0;
    repeat (30) next_edge();
    lit("retrig", 1, 2, 6, 16'h000C, 16'h000F, 16'h0010);

    // Randomised phase: inputs change every cycle, so latching is exercised too.
    for (int i = 0; i < 4000; i++) begin
      next_edge();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) start = ~start;
      abort = ($urandom_range(0, 59) == 0);
      delay = $urandom_range(0, 6);
      width = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
`ifdef PULSE_SEQUENCER_BURST_EN
      burst = 16'($urandom_range(0, 3));
      period = $urandom_range(0, 3);
`endif
    end
    next_edge();
    rst_n = 1'b1;
    abort = 1'b0;
    start = 1'b0;
    repeat (60) next_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
